io_bus_responder: RTL and testbench

Bus-side responder for the I/O window of the shared 32-bit memory bus. It answers burst read and write transactions that the arbiter decoder enables through its I/O enable, the same way main memory answers memory-window transactions. It holds a small bank of 32-bit device registers. Masters such as the instruction cache and the system controller reach it through the shared bus, and its data output is muxed or tri-stated onto the bus data lines at the subsystem top.

---
 rtl/io_bus_responder.sv | 143 ++++++++++++++
 tb/tb_io_bus_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/io_bus_responder.sv
// io_bus_responder
// Bus-side responder for the I/O window of the shared 32-bit memory bus.
// Answers fixed-length wrapping burst reads and writes into a small bank of
// 32-bit device registers. Every transaction is 2^BEATW beats, preceded by
// LAT wait cycles after acceptance. All outputs are registered.
//
// Optional feature macro: IO_RESP_BUSY_EN
//   defined   -> busy is high from the cycle after acceptance through the
//                last beat, so the arbiter cannot regrant mid-burst.
//   undefined -> busy is tied low and no busy logic is built.
module io_bus_responder #(
    parameter int IDXW  = 4,   // register index width, bank depth = 2^IDXW
    parameter int BEATW = 2,   // burst length exponent, 2^BEATW beats
    parameter int LAT   = 2    // wait cycles between acceptance and first beat
) (
    input  logic        clk,
    input  logic        reset,     // asynchronous, active-low
    input  logic        en,
    input  logic        rd_wr,     // 0 = read, 1 = write
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        data_oe,
    output logic        valid,
    output logic        busy
);

    localparam int DEPTH = 1 << IDXW;
    localparam int NBEAT = 1 << BEATW;
    localparam logic [IDXW-1:0] WRAP_MASK = IDXW'(NBEAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        XFER
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       wait_q,  wait_d;
    logic [BEATW-1:0] beat_q,  beat_d;
    logic [IDXW-1:0]  start_q, start_d;
    logic             write_q, write_d;
    logic [IDXW-1:0]  cur_idx;
    logic [IDXW-1:0]  nxt_idx;
    logic [31:0]      bank [DEPTH];

    // Beat index: the low BEATW bits advance and wrap, the upper bits stay
    // fixed, so a burst never leaves its aligned block.
    function automatic logic [IDXW-1:0] beat_index(input logic [IDXW-1:0]  start,
                                                   input logic [BEATW-1:0] beat);
        return (start & ~WRAP_MASK) | ((start + IDXW'(beat)) & WRAP_MASK);
    endfunction

    assign cur_idx = beat_index(start_q, beat_q);
    assign nxt_idx = beat_index(start_d, beat_d);

    // Next-state logic: accept in IDLE, count latency in WAIT, step beats in XFER.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        start_d = start_q;
        write_d = write_q;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    start_d = addr[IDXW+1:2];
                    write_d = rd_wr;
                    beat_d  = '0;
                    wait_d  = '0;
                    state_d = (LAT == 0) ? XFER : WAIT;
                end
            end
            WAIT: begin
                wait_d = wait_q + 4'd1;
                if (wait_d == 4'(LAT)) state_d = XFER;
            end
            XFER: begin
                if (beat_q == '1) state_d = IDLE;
                else              beat_d  = beat_q + BEATW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state register; en is only looked at in IDLE, so dropping it
    // cannot abort a transaction.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its inputs.
        if (!reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            beat_q  <= '0;
            start_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            start_q <= start_d;
            write_q <= write_d;
        end
    end

    // Registered beat outputs, driven from the next state so they line up
    // with the beat cycle itself; read data reflects the bank before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid    <= 1'b0;
            data_oe  <= 1'b0;
            data_out <= '0;
        end else begin
            valid    <= (state_d == XFER);
            data_oe  <= (state_d == XFER) && !write_d;
            data_out <= ((state_d == XFER) && !write_d) ? bank[nxt_idx] : '0;
        end
    end

    // Register bank: write beats commit data_in at the edge ending the beat.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: the bank must clear on reset, which makes it a flop array
        // rather than a RAM; fine at this depth.
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else if ((state_q == XFER) && write_q) begin
            bank[cur_idx] <= data_in;
        end
    end

`ifdef IO_RESP_BUSY_EN
    // Busy covers every cycle after acceptance up to and including the last beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy <= 1'b0;
        else        busy <= (state_d != IDLE);
    end
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_responder.sv
// tb_io_bus_responder
// Directed plus randomized bench for io_bus_responder. A register-bank model
// (plain array, burst index from div/mod arithmetic) predicts read data;
// beat timing is predicted from the cycle number relative to acceptance.
// A second instance built with LAT=0 covers the zero-latency back-to-back case.
module tb_io_bus_responder;

    localparam int LAT   = 2;
    localparam int NBEAT = 4;
    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic        en;
    logic        en0;
    logic        rd_wr;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out,  data_out0;
    logic        data_oe,   data_oe0;
    logic        valid,     valid0;
    logic        busy,      busy0;

    logic [31:0] model [DEPTH];
    logic [31:0] wbuf  [NBEAT];
    int          vectors;
    int          miscompares;

    io_bus_responder #(.IDXW(4), .BEATW(2), .LAT(LAT)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .rd_wr    (rd_wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .valid    (valid),
        .busy     (busy)
    );

    io_bus_responder #(.IDXW(4), .BEATW(2), .LAT(0)) u_dut_lat0 (
        .clk      (clk),
        .reset    (reset),
        .en       (en0),
        .rd_wr    (rd_wr),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out0),
        .data_oe  (data_oe0),
        .valid    (valid0),
        .busy     (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle later, just after the rising edge: outputs are settled and
    // inputs set now are sampled at the next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_busy(input bit active);
`ifdef IO_RESP_BUSY_EN
        return active;
`else
        return 1'b0;
`endif
    endfunction

    // Register touched by beat i of a burst starting at register 'start'.
    function automatic int model_idx(input int start, input int i);
        return (start / NBEAT) * NBEAT + ((start % NBEAT) + i) % NBEAT;
    endfunction

    // Full transaction on the main instance: called in an IDLE cycle (cycle 0),
    // returns in cycle LAT+5 with en low. pulse=1 toggles en during the burst.
    task automatic txn(input bit wr, input logic [31:0] a, input bit pulse);
        int  start;
        int  i;
        bit  in_beat;
        start = int'(a[5:2]);
        en    = 1'b1;
        rd_wr = wr;
        addr  = a;
        check("c0 valid", {31'b0, valid}, 32'd0);
        for (int c = 1; c <= LAT + NBEAT + 1; c++) begin
            step();
            en      = pulse && (c >= 3) && (c <= LAT + NBEAT);
            rd_wr   = 1'($urandom);
            addr    = $urandom;
            in_beat = (c >= LAT + 1) && (c <= LAT + NBEAT);
            i       = c - LAT - 1;
            data_in = (in_beat && wr) ? wbuf[i] : $urandom;
            check($sformatf("c%0d valid", c),   {31'b0, valid},   {31'b0, in_beat});
            check($sformatf("c%0d data_oe", c), {31'b0, data_oe}, {31'b0, in_beat && !wr});
            check($sformatf("c%0d busy", c),    {31'b0, busy},
                  {31'b0, exp_busy(c <= LAT + NBEAT)});
            if (in_beat && !wr)
                check($sformatf("c%0d rdata", c), data_out, model[model_idx(start, i)]);
        end
        if (wr)
            for (int k = 0; k < NBEAT; k++) model[model_idx(start, k)] = wbuf[k];
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b0;
        en      = 1'b0;
        en0     = 1'b0;
        rd_wr   = 1'b0;
        addr    = '0;
        data_in = '0;
        for (int k = 0; k < DEPTH; k++) model[k] = '0;

        // Reset values
        #12;
        check("rst valid",    {31'b0, valid},   32'd0);
        check("rst data_oe",  {31'b0, data_oe}, 32'd0);
        check("rst data_out", data_out,         32'd0);
        check("rst busy",     {31'b0, busy},    32'd0);
        #1 reset = 1'b1;
        step();

        // Read at 0xC after reset: start index 3, wraps 3,0,1,2, all zero
        txn(1'b0, 32'h0000_000C, 1'b0);

        // Write A0..A3 at 0x8, read back at 0x8 and wrapped at 0x0
        for (int k = 0; k < NBEAT; k++) wbuf[k] = 32'hA0 + k;
        txn(1'b1, 32'h0000_0008, 1'b0);
        txn(1'b0, 32'h0000_0008, 1'b0);
        txn(1'b0, 32'h0000_0000, 1'b0);

        // en pulses in WAIT/XFER must not cause a second acceptance
        txn(1'b0, 32'h0000_0004, 1'b1);

        // Zero-latency instance: en held through cycle 5 gives back-to-back bursts
        rd_wr = 1'b0;
        addr  = 32'h0000_0020;
        en0   = 1'b1;
        check("b2b c0 valid0", {31'b0, valid0}, 32'd0);
        for (int c = 1; c <= 10; c++) begin
            bit exp_v;
            step();
            en0   = (c <= 5);
            exp_v = ((c >= 1) && (c <= 4)) || ((c >= 6) && (c <= 9));
            check($sformatf("b2b c%0d valid0", c),   {31'b0, valid0},   {31'b0, exp_v});
            check($sformatf("b2b c%0d data_oe0", c), {31'b0, data_oe0}, {31'b0, exp_v});
            if (exp_v) check($sformatf("b2b c%0d rdata0", c), data_out0, 32'd0);
        end
        en0 = 1'b0;
        step();

        // Reset during the second beat of a write burst
        en    = 1'b1;
        rd_wr = 1'b1;
        addr  = 32'h0000_0008;
        for (int c = 1; c <= LAT + 2; c++) begin
            step();
            en      = 1'b0;
            data_in = $urandom;
        end
        check("mid pre valid", {31'b0, valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid valid",   {31'b0, valid},   32'd0);
        check("mid data_oe", {31'b0, data_oe}, 32'd0);
        check("mid busy",    {31'b0, busy},    32'd0);
        step();
        #2 reset = 1'b1;
        for (int k = 0; k < DEPTH; k++) model[k] = '0;
        step();
        txn(1'b0, 32'h0000_0008, 1'b0);

        // Randomized traffic against the bank model
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < NBEAT; k++) wbuf[k] = $urandom;
            txn(1'($urandom), $urandom, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
